// File: rtl/hazard_scoreboard_unit.sv
// Register/flag scoreboard for an in-order pipeline: tracks results that are not yet
// forwardable and stalls IF/ID when the instruction in ID would consume one too early.
module hazard_scoreboard_unit #(
  parameter int NREG     = 8,
  parameter int RW       = 3,
  parameter int LOAD_LAT = 1,
  parameter int FLAG_LAT = 1,
  parameter int SCW      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic            id_rs1_en,
  input  logic            id_rs2_en,
  input  logic            id_wr_en,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_is_load,
  input  logic            id_sets_flags,
  input  logic            id_is_branch,
  input  logic            flush,
  input  logic            clr_stats,
  output logic            PCWrite,
  output logic            IFWrite,
  output logic            IDEX_ctrl_flush,
  output logic [NREG-1:0] busy,
  output logic [SCW-1:0]  stall_cycles
);

  localparam logic [2:0] LOAD_CNT      = 3'(LOAD_LAT);
  localparam logic [3:0] FLAG_ALU_CNT  = 4'(FLAG_LAT);
  localparam logic [3:0] FLAG_LOAD_CNT = 4'(FLAG_LAT + LOAD_LAT);

  logic [2:0] cnt [NREG];
  logic [3:0] fcnt;
  logic       src_hz;
  logic       flag_hz;
  logic       hz;
  logic       issue;

  function automatic logic [2:0] dec3(input logic [2:0] c);
    return (c == 3'd0) ? 3'd0 : c - 3'd1;
  endfunction

  function automatic logic [3:0] dec4(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

  function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] c);
    return (&c) ? c : c + SCW'(1);
  endfunction

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREG; i++) busy[i] = (cnt[i] != 3'd0);
  end

  // Hazard detection reads the counts as they stand before this cycle's update,
  // so an instruction can never stall on the register it is about to write.
  assign src_hz  = (id_rs1_en & busy[id_rs1]) | (id_rs2_en & busy[id_rs2]);
  assign flag_hz = id_is_branch & (fcnt != 4'd0);
  assign hz      = id_valid & ~flush & (src_hz | flag_hz);
  assign issue   = id_valid & ~flush & ~hz;

  assign PCWrite         = ~hz;
  assign IFWrite         = ~hz;
  assign IDEX_ctrl_flush = hz | flush;

  // Newest writer replaces any outstanding count; ALU results are forwardable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= 3'd0;
      fcnt <= 4'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (issue && id_wr_en && (id_rd == RW'(i)))
          cnt[i] <= id_is_load ? LOAD_CNT : 3'd0;
        else
          cnt[i] <= dec3(cnt[i]);
      end
      if (issue && id_sets_flags)
        fcnt <= id_is_load ? FLAG_LOAD_CNT : FLAG_ALU_CNT;
      else
        fcnt <= dec4(fcnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stall_cycles <= '0;
    else if (clr_stats) stall_cycles <= '0;
    else if (hz)        stall_cycles <= sat_inc(stall_cycles);
  end

endmodule
